// File: rtl/ddfs_phase_seg_if.sv
// ddfs_phase_seg_if: groups the control inputs and the segmented phase outputs
// of the DDFS phase front end. The master modport is the controller/consumer
// side; the slave modport is the phase generator itself.
interface ddfs_phase_seg_if #(
    parameter int ACC_W    = 32,
    parameter int COARSE_W = 5
);
    localparam int P_W = 2 + COARSE_W + 9;

    logic                run;
    logic [ACC_W-1:0]    fcw_in;
    logic                fcw_load;
    logic [P_W-1:0]      phase_off;
    logic                fcw_pending;
    logic                wrap;
    logic [1:0]          quad;
    logic [COARSE_W-1:0] coarse_addr;
    logic [8:0]          phi_rot;
    logic [2:0]          en;
    logic                out_valid;

    modport master (
        output run, fcw_in, fcw_load, phase_off,
        input  fcw_pending, wrap, quad, coarse_addr, phi_rot, en, out_valid
    );

    modport slave (
        input  run, fcw_in, fcw_load, phase_off,
        output fcw_pending, wrap, quad, coarse_addr, phi_rot, en, out_valid
    );
endinterface

// File: rtl/ddfs_phase_seg.sv
// ddfs_phase_seg: DDFS phase accumulator with phase-continuous FCW updates,
// phase offset, truncation and split into quadrant / coarse address / fine
// rotation angle with per-segment enables for the rotation stage.
// Optional feature macro: PHASE_DITHER_EN (LFSR dither below truncation point).
module ddfs_phase_seg #(
    parameter int ACC_W    = 32,
    parameter int COARSE_W = 5
`ifdef PHASE_DITHER_EN
    ,
    parameter int DITHER_W = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    ddfs_phase_seg_if.slave   bus
);
    localparam int P_W = 2 + COARSE_W + 9;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mode_e;

    // Segment enables: a 3-bit segment is active whenever any of its bits is set.
    function automatic logic [2:0] seg_enables(input logic [8:0] phi);
        return {|phi[8:6], |phi[5:3], |phi[2:0]};
    endfunction

    mode_e               mode_s;
    logic [ACC_W:0]      sum_s;
    logic                apply_s;
    logic [P_W-1:0]      trunc_s;

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    fcw_active_q, fcw_active_d;
    logic [ACC_W-1:0]    fcw_pend_q, fcw_pend_d;
    logic                fcw_pending_q, fcw_pending_d;
    logic                wrap_q, wrap_d;
    logic [P_W-1:0]      phase_q, phase_d;
    logic                valid1_q;
    logic [1:0]          quad_q;
    logic [COARSE_W-1:0] coarse_q;
    logic [8:0]          phi_q;
    logic [2:0]          en_q;
    logic                valid_q;

`ifdef PHASE_DITHER_EN
    localparam int D_TOP = P_W + DITHER_W;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic [15:0]      lfsr_q, lfsr_d;
    logic [D_TOP-1:0] dith_sum_s;

    // Dithered truncation: add LFSR bits just below the cut, carry into the phase.
    always_comb begin
        if (bus.run) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
        dith_sum_s = acc_q[ACC_W-1 -: D_TOP] + {{P_W{1'b0}}, lfsr_q[DITHER_W-1:0]};
        trunc_s    = dith_sum_s[D_TOP-1 -: P_W];
    end

    // LFSR state register; advances only while running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Pure truncation of the accumulator to the phase width.
    always_comb begin
        trunc_s = acc_q[ACC_W-1 -: P_W];
    end
`endif

    // Next state: accumulate in RUN, FCW capture/apply rules, stage-1 phase.
    always_comb begin
        mode_s       = bus.run ? RUN : IDLE;
        sum_s        = {1'b0, acc_q} + {1'b0, fcw_active_q};
        acc_d        = acc_q;
        wrap_d       = 1'b0;
        apply_s      = 1'b0;
        case (mode_s)
            RUN: begin
                acc_d   = sum_s[ACC_W-1:0];
                wrap_d  = sum_s[ACC_W];
                apply_s = fcw_pending_q & sum_s[ACC_W];
            end
            IDLE: begin
                apply_s = fcw_pending_q;
            end
            default: begin
                apply_s = 1'b0;
            end
        endcase

        if (apply_s) begin
            fcw_active_d = fcw_pend_q;
        end else begin
            fcw_active_d = fcw_active_q;
        end

        // A fresh capture always wins over clearing the pending flag.
        if (bus.fcw_load) begin
            fcw_pend_d    = bus.fcw_in;
            fcw_pending_d = 1'b1;
        end else if (apply_s) begin
            fcw_pend_d    = fcw_pend_q;
            fcw_pending_d = 1'b0;
        end else begin
            fcw_pend_d    = fcw_pend_q;
            fcw_pending_d = fcw_pending_q;
        end

        phase_d = trunc_s + bus.phase_off;
    end

    // Accumulator, FCW registers, stage-1 phase and stage-2 segmented outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q         <= {ACC_W{1'b0}};
            fcw_active_q  <= {ACC_W{1'b0}};
            fcw_pend_q    <= {ACC_W{1'b0}};
            fcw_pending_q <= 1'b0;
            wrap_q        <= 1'b0;
            phase_q       <= {P_W{1'b0}};
            valid1_q      <= 1'b0;
            quad_q        <= 2'd0;
            coarse_q      <= {COARSE_W{1'b0}};
            phi_q         <= 9'd0;
            en_q          <= 3'd0;
            valid_q       <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            fcw_active_q  <= fcw_active_d;
            fcw_pend_q    <= fcw_pend_d;
            fcw_pending_q <= fcw_pending_d;
            wrap_q        <= wrap_d;
            phase_q       <= phase_d;
            valid1_q      <= bus.run;
            quad_q        <= phase_q[P_W-1 -: 2];
            coarse_q      <= phase_q[P_W-3 -: COARSE_W];
            phi_q         <= phase_q[8:0];
            en_q          <= seg_enables(phase_q[8:0]);
            valid_q       <= valid1_q;
        end
    end

    assign bus.fcw_pending = fcw_pending_q;
    assign bus.wrap        = wrap_q;
    assign bus.quad        = quad_q;
    assign bus.coarse_addr = coarse_q;
    assign bus.phi_rot     = phi_q;
    assign bus.en          = en_q;
    assign bus.out_valid   = valid_q;
endmodule
